// File: rtl/maxpool2x2_layer1.sv
// maxpool2x2_layer1: streaming 2x2 stride-2 max pooling, 8 channels.
// One half-row of horizontal maxima is buffered per channel.
module maxpool2x2_layer1 #(
  parameter int IMG_W = 28,
  parameter int IMG_H = 28
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [7:0] in_data0,
  input  logic [7:0] in_data1,
  input  logic [7:0] in_data2,
  input  logic [7:0] in_data3,
  input  logic [7:0] in_data4,
  input  logic [7:0] in_data5,
  input  logic [7:0] in_data6,
  input  logic [7:0] in_data7,
  output logic       out_valid,
  output logic [7:0] out_pool0,
  output logic [7:0] out_pool1,
  output logic [7:0] out_pool2,
  output logic [7:0] out_pool3,
  output logic [7:0] out_pool4,
  output logic [7:0] out_pool5,
  output logic [7:0] out_pool6,
  output logic [7:0] out_pool7,
  output logic       out_last
);

  localparam int HW = IMG_W / 2;
  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int AW = (HW > 1) ? $clog2(HW) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;

  logic [7:0] din      [8];
  logic [7:0] hold_q   [8];
  logic [7:0] rowbuf_q [8][HW];
  logic [7:0] hmax     [8];
  logic [7:0] res      [8];
  logic [7:0] pool_q   [8];

  logic          valid_q;
  logic          last_q;
  logic [AW-1:0] idx;
  logic          odd_col;
  logic          odd_row;
  logic          col_end;
  logic          row_end;
  logic          fire;

  assign din[0] = in_data0;
  assign din[1] = in_data1;
  assign din[2] = in_data2;
  assign din[3] = in_data3;
  assign din[4] = in_data4;
  assign din[5] = in_data5;
  assign din[6] = in_data6;
  assign din[7] = in_data7;

  // Beat position decode and per-channel compare/select network
  always_comb begin
    idx     = AW'(col_q >> 1);
    odd_col = col_q[0];
    odd_row = row_q[0];
    col_end = (col_q == COL_LAST);
    row_end = (row_q == ROW_LAST);
    fire    = in_valid & odd_col & odd_row;
    for (int ch = 0; ch < 8; ch++) begin
      hmax[ch] = (hold_q[ch] > din[ch]) ? hold_q[ch] : din[ch];
      res[ch]  = (hmax[ch] > rowbuf_q[ch][idx]) ?
                 hmax[ch] : rowbuf_q[ch][idx];
    end
  end

  // Raster position: column wraps into row, row wraps into a new frame
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (in_valid) begin
      if (col_end) begin
        col_d = '0;
        row_d = row_end ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  // Position counters; reset starts a fresh frame
  always_ff @(posedge clk) begin
    if (rst) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  // Hold and row buffers need no reset: always written before being read
  always_ff @(posedge clk) begin
    for (int ch = 0; ch < 8; ch++) begin
      if (in_valid) begin
        if (!odd_col) begin
          hold_q[ch] <= din[ch];
        end else if (!odd_row) begin
          rowbuf_q[ch][idx] <= hmax[ch];
        end
      end
    end
  end

  // Registered pooled result; values hold between output pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      for (int ch = 0; ch < 8; ch++) begin
        pool_q[ch] <= '0;
      end
    end else begin
      valid_q <= fire;
      last_q  <= fire & col_end & row_end;
      for (int ch = 0; ch < 8; ch++) begin
        if (fire) begin
          pool_q[ch] <= res[ch];
        end
      end
    end
  end

  assign out_valid = valid_q;
  assign out_last  = last_q;
  assign out_pool0 = pool_q[0];
  assign out_pool1 = pool_q[1];
  assign out_pool2 = pool_q[2];
  assign out_pool3 = pool_q[3];
  assign out_pool4 = pool_q[4];
  assign out_pool5 = pool_q[5];
  assign out_pool6 = pool_q[6];
  assign out_pool7 = pool_q[7];

endmodule

// File: tb/tb_maxpool2x2_layer1.sv
// tb_maxpool2x2_layer1: frame-level reference bench for the
// 2x2 max-pooling stage (window maxima, latency, last flag).
module tb_maxpool2x2_layer1;

  localparam int W    = 28;
  localparam int H    = 28;
  localparam int OW   = 14;
  localparam int OH   = 14;
  localparam int NOUT = 196;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] din  [8];
  logic [7:0] pool [8];
  logic       out_valid;
  logic       out_last;

  always #5 clk = ~clk;

  maxpool2x2_layer1 #(.IMG_W(W), .IMG_H(H)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_data0 (din[0]),
    .in_data1 (din[1]),
    .in_data2 (din[2]),
    .in_data3 (din[3]),
    .in_data4 (din[4]),
    .in_data5 (din[5]),
    .in_data6 (din[6]),
    .in_data7 (din[7]),
    .out_valid(out_valid),
    .out_pool0(pool[0]),
    .out_pool1(pool[1]),
    .out_pool2(pool[2]),
    .out_pool3(pool[3]),
    .out_pool4(pool[4]),
    .out_pool5(pool[5]),
    .out_pool6(pool[6]),
    .out_pool7(pool[7]),
    .out_last (out_last)
  );

  int checks   = 0;
  int failures = 0;

  logic [7:0] frm     [8][H][W];
  logic [7:0] got     [8][OH][OW];
  logic [7:0] got_ref [8][OH][OW];

  logic        exp_v;
  logic        exp_l;
  logic [63:0] exp_p;
  int          n_out;
  int          n_last;
  int          oi;

  typedef struct {
    int         r;
    int         c;
    int         ch;
    logic [7:0] val;
    int         er;
    int         ec;
  } qv_t;

  qv_t tbl [6];

  function automatic logic [7:0] mx(input logic [7:0] a,
                                    input logic [7:0] b);
    return (a > b) ? a : b;
  endfunction

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s got=%0d required=%0d", nm, act, req);
    end
  endtask

  task automatic cyc();
    logic [63:0] act;
    @(posedge clk);
    #1;
    for (int ch = 0; ch < 8; ch++) act[ch*8 +: 8] = pool[ch];
    checks++;
    if (out_valid !== exp_v || out_last !== exp_l || act !== exp_p) begin
      failures++;
      $display("FAIL cycle t=%0t valid=%b last=%b pool=%h required valid=%b last=%b pool=%h",
               $time, out_valid, out_last, act, exp_v, exp_l, exp_p);
    end
    if (out_valid === 1'b1) begin
      if (oi < NOUT)
        for (int ch = 0; ch < 8; ch++)
          got[ch][oi / OW][oi % OW] = act[ch*8 +: 8];
      oi++;
      n_out++;
      if (out_last === 1'b1) n_last++;
    end
  endtask

  task automatic beat(input int r, input int c);
    in_valid = 1'b1;
    for (int ch = 0; ch < 8; ch++) din[ch] = frm[ch][r][c];
    if ((r % 2 == 1) && (c % 2 == 1)) begin
      exp_v = 1'b1;
      exp_l = (r == H - 1) && (c == W - 1);
      for (int ch = 0; ch < 8; ch++)
        exp_p[ch*8 +: 8] = mx(mx(frm[ch][r-1][c-1], frm[ch][r-1][c]),
                              mx(frm[ch][r][c-1], frm[ch][r][c]));
    end else begin
      exp_v = 1'b0;
      exp_l = 1'b0;
    end
    cyc();
  endtask

  task automatic idle();
    in_valid = 1'b0;
    for (int ch = 0; ch < 8; ch++) din[ch] = 8'($urandom);
    exp_v = 1'b0;
    exp_l = 1'b0;
    cyc();
  endtask

  task automatic run_frame(input bit bub, input int nb);
    oi = 0;
    for (int i = 0; i < nb; i++) begin
      if (bub)
        for (int k = 0; k < 3; k++)
          if ($urandom_range(1) == 1) idle();
      beat(i / W, i % W);
    end
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    in_valid = 1'b1;
    for (int ch = 0; ch < 8; ch++) din[ch] = 8'($urandom);
    exp_v = 1'b0;
    exp_l = 1'b0;
    exp_p = '0;
    cyc();
    rst = 1'b0;
  endtask

  task automatic clr();
    n_out  = 0;
    n_last = 0;
  endtask

  task automatic fill(input int mode);
    for (int ch = 0; ch < 8; ch++)
      for (int r = 0; r < H; r++)
        for (int c = 0; c < W; c++)
          case (mode)
            0: frm[ch][r][c] = 8'((r * W + c + ch) & 8'h7F);
            1: frm[ch][r][c] = 8'($urandom);
            2: frm[ch][r][c] = 8'h00;
            default: frm[ch][r][c] = (r % 2 == 0) ? 8'hFF : 8'h7F;
          endcase
  endtask

  initial begin
    int nz;
    int hit;
    tbl[0] = '{r: 0,  c: 0,  ch: 3, val: 8'd100, er: 0,  ec: 0};
    tbl[1] = '{r: 0,  c: 3,  ch: 3, val: 8'd100, er: 0,  ec: 1};
    tbl[2] = '{r: 3,  c: 0,  ch: 3, val: 8'd100, er: 1,  ec: 0};
    tbl[3] = '{r: 3,  c: 3,  ch: 3, val: 8'd100, er: 1,  ec: 1};
    tbl[4] = '{r: 27, c: 27, ch: 7, val: 8'd255, er: 13, ec: 13};
    tbl[5] = '{r: 26, c: 1,  ch: 0, val: 8'd128, er: 13, ec: 0};

    rst      = 1'b0;
    in_valid = 1'b0;
    for (int ch = 0; ch < 8; ch++) din[ch] = '0;
    oi = 0;
    clr();
    do_reset();
    do_reset();

    // ramp, continuous
    fill(0);
    clr();
    run_frame(1'b0, W * H);
    idle();
    chk("ramp_outputs", n_out, NOUT);
    chk("ramp_last", n_last, 1);
    chk("ramp_00_ch0", int'(got[0][0][0]), 29);
    chk("ramp_00_ch5", int'(got[5][0][0]), 34);
    got_ref = got;

    // ramp with bubbles
    clr();
    run_frame(1'b1, W * H);
    idle();
    chk("bubble_outputs", n_out, NOUT);
    chk("bubble_last", n_last, 1);
    nz = 0;
    for (int ch = 0; ch < 8; ch++)
      for (int r = 0; r < OH; r++)
        for (int c = 0; c < OW; c++)
          if (got[ch][r][c] != got_ref[ch][r][c]) nz++;
    chk("bubble_vs_continuous", nz, 0);

    // single hot pixel table
    for (int t = 0; t < 6; t++) begin
      fill(2);
      frm[tbl[t].ch][tbl[t].r][tbl[t].c] = tbl[t].val;
      clr();
      run_frame(1'b0, W * H);
      chk("quad_count", n_out, NOUT);
      chk("quad_hit", int'(got[tbl[t].ch][tbl[t].er][tbl[t].ec]),
          int'(tbl[t].val));
      nz = 0;
      for (int ch = 0; ch < 8; ch++)
        for (int r = 0; r < OH; r++)
          for (int c = 0; c < OW; c++) begin
            hit = (ch == tbl[t].ch && r == tbl[t].er && c == tbl[t].ec);
            if (hit == 0 && got[ch][r][c] != 8'h00) nz++;
          end
      chk("quad_others_zero", nz, 0);
    end

    // back-to-back random frames
    clr();
    fill(1);
    run_frame(1'b0, W * H);
    fill(1);
    run_frame(1'b0, W * H);
    idle();
    chk("b2b_outputs", n_out, 2 * NOUT);
    chk("b2b_last", n_last, 2);

    // reset in the middle of a frame
    fill(1);
    run_frame(1'b0, 300);
    do_reset();
    fill(1);
    clr();
    run_frame(1'b1, W * H);
    idle();
    chk("rst_outputs", n_out, NOUT);
    chk("rst_last", n_last, 1);

    // saturated values exercise unsigned compare
    fill(3);
    clr();
    run_frame(1'b0, W * H);
    idle();
    nz = 0;
    for (int ch = 0; ch < 8; ch++)
      for (int r = 0; r < OH; r++)
        for (int c = 0; c < OW; c++)
          if (got[ch][r][c] != 8'hFF) nz++;
    chk("sat_all_ff", nz, 0);
    chk("sat_outputs", n_out, NOUT);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/maxpool2x2_layer1.md
# maxpool2x2_layer1

Streaming 2×2, stride-2 max-pooling stage placed directly after the first 3×3 convolution/ReLU layer. It consumes the 8-channel, 28×28 raster stream of unsigned 8-bit activations from that layer and emits a 14×14, 8-channel pooled stream in raster order. All eight channels are pooled in parallel. It buffers one half-width row of horizontal maxima per channel, so it runs at full input rate with no backpressure.

## Interface
- IMG_W, 28, input frame width in pixels; must be even and ≥ 2
- IMG_H, 28, input frame height in pixels; must be even and ≥ 2
- clk  input  1  single clock; all logic on rising edge
- rst  input  1  reset, synchronous, active-high
- in_valid  input  1  one input pixel (all 8 channels) presented this cycle
- in_data0 … in_data7  input  8 each  unsigned activation, channel 0–7
- out_valid  output  1  pooled pixel valid, 1-cycle pulse per output
- out_pool0 … out_pool7  output  8 each  unsigned pooled value, channel 0–7
- out_last  output  1  asserted together with out_valid on the final (bottom-right) pooled pixel of a frame

## Operation
- col_cnt in 0..IMG_W-1 and row_cnt in 0..IMG_H-1 advance only on in_valid beats.
  - col wraps to 0 after IMG_W-1 and increments row.
  - row wraps to 0 after IMG_H-1, which starts a new frame.
- Gaps in in_valid (any length) are allowed and freeze all state. Outputs hold their values and out_valid is 0.
- Per channel:
  - Even col beat: latch in_data into the hold register.
  - Odd col beat: hmax = max(hold, in_data), unsigned compare.
    - Even row: write hmax to rowbuf[col_cnt>>1]. The rowbuf has IMG_W/2 entries × 8 bits.
    - Odd row: result = max(hmax, rowbuf[col_cnt>>1]). Register it to out_poolN and assert out_valid next cycle.
- Output window (r,c) covers input rows 2r, 2r+1 and cols 2c, 2c+1.
- Output order is raster: (0,0), (0,1) … (0,IMG_W/2-1), (1,0) … Output count is (IMG_W/2)·(IMG_H/2) per frame.
- out_last = out_valid for the window that came from the beat at row IMG_H-1, col IMG_W-1.
- No arithmetic widening is needed; the data path is pure compare/select on 8-bit unsigned values.
- rowbuf and hold registers are not reset. Every rowbuf entry is written in an even row before it is read in the following odd row.

## Timing
- Reset (rst=1 at a clock edge) sets:
  - out_valid=0, out_last=0, out_pool0..7=0
  - col_cnt=0, row_cnt=0
  - Reset takes priority over in_valid in the same cycle.
- Reset mid-frame: the partial frame is discarded. The first in_valid beat after rst deasserts is pixel (0,0) of a new frame. No output is produced from pre-reset data.
- Latency: out_valid is high exactly 1 cycle after the in_valid beat at (odd row, odd col).
- out_valid is never high on two consecutive cycles, because at least one even-col beat separates outputs.
- out_poolN keeps its last value while out_valid=0.
- Back-to-back frames: the beat after (IMG_H-1, IMG_W-1) is (0,0) of the next frame, with no idle cycle required. The final output of frame k and the first even-col hold of frame k+1 occur in the same cycle without interaction.
- Throughput: 1 input pixel/cycle sustained. Output rate is 1 per 4 input beats on average, all during odd rows.

## Test plan
- **Ramp frame:** continuous in_valid, channel N pixel (r,c) = (r·28+c+N)&0x7F.
  - Expect 196 outputs with out_poolN(r',c') = ((2r'+1)·28+2c'+1+N)&0x7F, taking wrap into account (golden model compares all four values).
  - out_last only on output 196.
- **Max position per quadrant:** all zeros except value 100 placed at (0,0), (0,3), (3,0), (3,3) of successive windows on channel 3.
  - Each affected output is 100 on channel 3 only; the other channels are 0.
- **Bubbles:** ramp frame with in_valid toggled pseudo-randomly (~50% duty).
  - Results are identical to the continuous run.
  - Each out_valid arrives exactly 1 cycle after the triggering beat.
- **Back-to-back frames:** two different random frames with no gap.
  - 392 outputs, matching a per-frame golden model.
  - out_last is asserted exactly twice.
- **Reset mid-frame:** assert rst for 1 cycle after 300 beats of frame A, then send full frame B.
  - out_valid=0 and out_pool=0 in the cycle after reset.
  - The next 196 outputs equal frame B's golden values.
- **Saturated values:** all inputs 0xFF on even rows and 0x7F on odd rows.
  - All outputs are 0xFF, confirming the compare is unsigned.
